// File: rtl/rv_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes, NOP word and the encoder.
// Pure definitions (no state). The encode helper is combinational.
// Imported by instr_encoder for field packing and format decode.
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = {12'd0, 5'd0, 3'd0, 5'd0, OPC_OP_IMM};

    // Output buffer entry: encoded word plus its byte address.
    localparam int ENTRY_W = 64;

    // Pack command fields into a 32-bit word; unknown formats become a NOP.
    function automatic logic [31:0] encode_instr(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = NOP_INSTR;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer (ordered FIFO) between the encoder and the memory write port.
// Latency 1: a word written on an edge is visible on out_data after that edge.
// in_ready comes only from the registered occupancy; it drops when both entries are full.
module skid_buf2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         wr;
    logic         rd;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign wr        = in_valid & in_ready;
    assign rd        = out_valid & out_ready;

    // Storage, pointers and occupancy; storage cleared so idle outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= in_data;
            end
            wr_ptr <= wr_ptr ^ wr;
            rd_ptr <= rd_ptr ^ rd;
            case ({wr, rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes RV32I command records into instruction words with sequential byte addresses.
// Latency 1 from command accept to out_valid; optional sticky range checks under INSTR_ENCODER_CHECK_EN.
// Backpressure: 2-entry skid buffer; in_ready falls when both entries are occupied.
module instr_encoder
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state;
    state_e              next_state;
    logic                buf_rdy;
    logic [1:0]          buf_cnt;
    logic                accept;
    logic                start_acc;
    logic [31:0]         addr_cnt;
    logic [31:0]         new_addr;
    logic [31:0]         enc_word;
    logic [ENTRY_W-1:0]  buf_out;

    assign accept    = in_valid & in_ready;
    assign start_acc = start & (state == S_IDLE);
    assign enc_word  = encode_instr(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                    in_funct3, in_funct7, in_imm);
    // addr_cnt tracks the head word; a new word lands behind everything still buffered.
    assign new_addr  = addr_cnt + {28'd0, buf_cnt, 2'b00};

    // Program state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, command-side ready and the completion pulse.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = buf_rdy;
                if (in_valid && buf_rdy && in_last) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (buf_cnt == 2'd0) begin
                    done       = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Address of the word at the buffer head; moves only when memory takes a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= 32'd0;
        end else if (start_acc) begin
            addr_cnt <= base_addr;
        end else if (out_valid && out_ready) begin
            addr_cnt <= addr_cnt + 32'd4;
        end
    end

    skid_buf2 #(.W(ENTRY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_ready  (buf_rdy),
        .in_data   ({enc_word, new_addr}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out),
        .count     (buf_cnt)
    );

    assign out_instr = buf_out[63:32];
    assign out_addr  = buf_out[31:0];

`ifdef INSTR_ENCODER_CHECK_EN
    logic bad_cmd;

    // Flag immediates that the selected format cannot represent, and unknown formats.
    always_comb begin
        bad_cmd = 1'b0;
        case (in_fmt)
            FMT_R:        bad_cmd = 1'b0;
            FMT_I, FMT_S: bad_cmd = (in_imm[31:11] != {21{in_imm[11]}});
            FMT_B:        bad_cmd = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            FMT_U:        bad_cmd = (in_imm[11:0] != 12'd0);
            FMT_J:        bad_cmd = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            default:      bad_cmd = 1'b1;
        endcase
    end

    // Sticky error, cleared when a new program starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (start_acc) begin
            err <= 1'b0;
        end else if (accept && bad_cmd) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Inputs driven 1 time unit after the rising edge; outputs sampled there or on the falling edge.
// Error expectations follow INSTR_ENCODER_CHECK_EN when it is defined for the build.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        done;
    logic        err;

`ifdef INSTR_ENCODER_CHECK_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] log_instr [64];
    logic [31:0] log_addr  [64];
    int          log_n  = 0;
    int          done_n = 0;
    int          log_base;
    int          done_base;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every output handshake (it completes on the next rising edge) and done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready && log_n < 64) begin
                log_instr[log_n] = out_instr;
                log_addr[log_n]  = out_addr;
                log_n++;
            end
            if (done) begin
                done_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input logic last);
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_last   = last;
        in_valid  = 1'b1;
    endtask

    // Present a command, wait (bounded) for in_ready, return 1 unit after the accepting edge.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last);
        int n;
        drive(fmt, op, rd, rs1, rs2, f3, f7, imm, last);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready_within_bound", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, then one more cycle so the FSM is back in IDLE.
    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk("done_within_bound", {31'd0, done}, 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0; in_last = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_err",       {31'd0, err},       32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr",  out_addr,  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Program at 0x100, all six formats back to back; a second start in RUN is ignored
        do_start(32'h0000_0100);
        chk("run_in_ready", {31'd0, in_ready}, 32'd1);
        start = 1'b1; base_addr = 32'h0000_5550;
        tick();
        start = 1'b0;
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_instr", out_instr, 32'h0050_0093);
        chk("addi_addr",  out_addr,  32'h0000_0100);
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_instr", out_instr, 32'h0020_81B3);
        chk("add_addr",  out_addr,  32'h0000_0104);
        send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 1'b0);
        chk("sw_valid", {31'd0, out_valid}, 32'd1);
        chk("sw_instr", out_instr, 32'h0020_A223);
        chk("sw_addr",  out_addr,  32'h0000_0108);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
        chk("beq_instr", out_instr, 32'h0020_8463);
        chk("beq_addr",  out_addr,  32'h0000_010C);
        send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b0);
        chk("jal_instr", out_instr, 32'h0100_00EF);
        chk("jal_addr",  out_addr,  32'h0000_0110);
        send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
        chk("lui_instr", out_instr, 32'h1234_52B7);
        chk("lui_addr",  out_addr,  32'h0000_0114);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("a_done_pulse", {31'd0, done}, 32'd1);
        tick();
        chk("a_done_low",  {31'd0, done}, 32'd0);
        chk("a_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("a_err_clean", {31'd0, err}, 32'd0);

        // Backpressure: out_ready low for 5 cycles, buffer fills, nothing dropped
        log_base  = log_n;
        done_base = done_n;
        do_start(32'h0000_0400);
        out_ready = 1'b0;
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_first_ready", {31'd0, in_ready},  32'd1);
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_instr", out_instr, 32'h0050_0093);
        drive(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_stall_instr", out_instr, 32'h0050_0093);
            chk("bp_stall_addr",  out_addr,  32'h0000_0400);
        end
        out_ready = 1'b1;
        send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 1'b1);
        wait_done();
        tick();
        chk("bp_word_count", log_n - log_base, 32'd3);
        chk("bp_done_count", done_n - done_base, 32'd1);
        chk("bp_w0_instr", log_instr[log_base],     32'h0050_0093);
        chk("bp_w0_addr",  log_addr[log_base],      32'h0000_0400);
        chk("bp_w1_instr", log_instr[log_base + 1], 32'h0020_81B3);
        chk("bp_w1_addr",  log_addr[log_base + 1],  32'h0000_0404);
        chk("bp_w2_instr", log_instr[log_base + 2], 32'h0020_A223);
        chk("bp_w2_addr",  log_addr[log_base + 2],  32'h0000_0408);

        // Address wrap-around
        do_start(32'hFFFF_FFFC);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        chk("wrap_addr0", out_addr, 32'hFFFF_FFFC);
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        chk("wrap_addr1", out_addr, 32'h0000_0000);
        chk("wrap_instr1", out_instr, 32'h0020_81B3);
        wait_done();

        // Reset in the middle of a stalled program
        do_start(32'h0000_0800);
        out_ready = 1'b0;
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("mid_rst_done",      {31'd0, done},      32'd0);
        chk("mid_rst_err",       {31'd0, err},       32'd0);
        chk("mid_rst_out_instr", out_instr, 32'd0);
        chk("mid_rst_out_addr",  out_addr,  32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, in_ready}, 32'd0);
        do_start(32'h0000_0010);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        chk("post_rst_addr",  out_addr,  32'h0000_0010);
        chk("post_rst_instr", out_instr, 32'h0050_0093);
        wait_done();

        // Range checks: misaligned branch offset, invalid format, then clear on start
        do_start(32'h0000_0000);
        chk("chk_err_start", {31'd0, err}, 32'd0);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0);
        chk("chk_b7_instr", out_instr, 32'h0020_8363);
        chk("chk_b7_err",   {31'd0, err}, ERR_EXP);
        send(3'd7, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        chk("chk_fmt7_instr", out_instr, 32'h0000_0013);
        chk("chk_fmt7_addr",  out_addr,  32'h0000_0004);
        chk("chk_fmt7_err",   {31'd0, err}, ERR_EXP);
        wait_done();
        chk("chk_err_sticky", {31'd0, err}, ERR_EXP);
        do_start(32'h0000_0000);
        chk("chk_err_cleared", {31'd0, err}, 32'd0);
        send(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        chk("chk_fmt6_instr", out_instr, 32'h0000_0013);
        chk("chk_fmt6_err",   {31'd0, err}, ERR_EXP);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: start  in  1  one-cycle pulse, loads address counter, enters RUN.
REQ-004 SHALL expose: base_addr  in  32  byte address of first word, sampled on start.
REQ-005 SHALL expose: in_valid / in_ready  in / out  1 / 1  command handshake.
REQ-006 SHALL expose: in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 invalid.
REQ-007 SHALL expose: in_opcode  in  7; in_rd, in_rs1, in_rs2  in  5 each; in_funct3  in  3; in_funct7  in  7; in_imm  in  32; in_last  in  1  final command of program.
REQ-008 SHALL expose: out_valid / out_ready  out / in  1 / 1  instruction-memory write handshake.
REQ-009 SHALL expose: out_instr  out  32; out_addr  out  32  byte address of out_instr.
REQ-010 SHALL expose: done  out  1  one-cycle pulse after last word accepted; err  out  1  sticky check flag.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on accepting command with in_last=1; DRAIN->IDLE when output side empty, asserting done for exactly that cycle.
REQ-012 SHALL hold in_ready=0 in IDLE and DRAIN; start outside IDLE SHALL be ignored.
REQ-013 SHALL encode: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-014 SHALL emit 32'h00000013 (NOP) for fmt 6/7.
REQ-015 SHALL present out_valid with encoded word one cycle after the accepting edge (latency 1).
REQ-016 SHALL use a 2-entry skid buffer so one command/cycle is sustained while out_ready=1; in_ready SHALL depend only on registered state.
REQ-017 SHALL drop nothing when out_ready deasserts: in_ready falls once both entries are occupied.
REQ-018 SHALL hold out_instr/out_addr stable while out_valid=1 and out_ready=0.
REQ-019 SHALL assign out_addr = base_addr + 4*n for the n-th emitted word; 32-bit wrap-around (0xFFFFFFFC -> 0x00000000) without flag.
REQ-020 SHALL let the counter advance only on output handshake.

Reset
REQ-021 SHALL on rst, at any time including mid-program: state IDLE, buffer empty, out_valid=0, in_ready=0, done=0, err=0, out_instr=0, out_addr=0.

Configuration
REQ-022 SHALL support macro INSTR_ENCODER_CHECK_EN; when defined, err sets (sticky until rst or next start) on accepting: fmt 6/7; B imm outside signed 13-bit or imm[0]=1; J outside signed 21-bit or imm[0]=1; I/S outside signed 12-bit; U imm[11:0]!=0; word still emitted per REQ-013/014.
REQ-023 SHALL, without the macro, tie err=0 and contain no check logic.

Structure
REQ-024 SHALL place fmt encodings, RV32I opcode constants and NOP value in shared package rv_pkg, used also by the decode/control logic.
REQ-025 SHALL isolate the skid buffer as sub-module skid_buf2 (parameterised width, 64 bits here: instr+addr).

Verification
REQ-026 start, base=0x100; I addi x1,x0,5 -> out_instr 0x00500093 at out_addr 0x100, one cycle after accept.
REQ-027 R add x3,x1,x2 then S sw x2,4(x1) back-to-back -> 0x002081B3 @base, 0x0020A223 @base+4, no bubble.
REQ-028 B beq x1,x2,+8 -> 0x00208463; J jal x1,+16 -> 0x010000EF; U lui x5,0x12345000 -> 0x123452B7.
REQ-029 out_ready low 5 cycles during stream -> in_ready falls after 2 accepts, outputs stable, order/addresses preserved; in_last -> done pulses once after final handshake.
REQ-030 base=0xFFFFFFFC, two commands -> addresses 0xFFFFFFFC, 0x00000000; rst mid-stream -> all outputs to REQ-021 values next cycle.
REQ-031 with INSTR_ENCODER_CHECK_EN: B imm=7 -> err=1, word still emitted; fmt=7 -> NOP and err=1; without macro err stays 0.
